// File: rtl/display_pkg.sv
// Shared display constants and types for the scanline compositor and its users.
package display_pkg;

  localparam int DEF_CORDW       = 10;
  localparam int DEF_LINE_PIXELS = 640;
  localparam int DEF_IDX_W       = 8;
  localparam int DEF_PAL_W       = 24;
  localparam int DEF_CH_W        = 4;

  // sx_next -> vga_* pixel latency in clocks
  localparam int LINE_LATENCY = 3;

  typedef logic [DEF_IDX_W-1:0] pal_idx_t;

  typedef struct packed {
    logic [DEF_CH_W-1:0] r;
    logic [DEF_CH_W-1:0] g;
    logic [DEF_CH_W-1:0] b;
  } rgb_t;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_e;

endpackage

// File: rtl/line_ram.sv
// One scanline bank: synchronous write, registered read, contents never reset.
module line_ram #(
  parameter int DEPTH = 640,
  parameter int DW    = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_compositor.sv
// Ping-pong scanline buffer: drawers fill the back bank while the front bank is
// scanned out through palette lookup, with auto-clear, 2x repeat and border.
module line_compositor
  import display_pkg::*;
#(
  parameter int CORDW       = DEF_CORDW,
  parameter int LINE_PIXELS = DEF_LINE_PIXELS,
  parameter int IDX_W       = DEF_IDX_W,
  parameter int PAL_W       = DEF_PAL_W,
  parameter int CH_W        = DEF_CH_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             line_start,
  input  logic             wr_en,
  input  logic [CORDW-1:0] wr_addr,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_done,
  input  logic [IDX_W-1:0] bg_idx,
  input  logic [IDX_W-1:0] border_idx,
  input  logic             scale2x,
  input  logic [CORDW-1:0] sx_next,
  input  logic             de_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  output logic [IDX_W-1:0] pal_addr,
  input  logic [PAL_W-1:0] pal_data,
  output logic             clear_busy,
  output logic             err_late,
  output logic             err_underrun,
  input  logic             err_clr,
  output logic [CH_W-1:0]  vga_r,
  output logic [CH_W-1:0]  vga_g,
  output logic [CH_W-1:0]  vga_b,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic             vga_de
);

  localparam int              AW        = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam int              LL        = LINE_LATENCY;
  localparam logic [CORDW:0]  LINE_LIM  = (CORDW+1)'(LINE_PIXELS);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(LINE_PIXELS - 1);

  clr_state_e              clr_state_q, clr_state_d;
  logic [AW-1:0]           clr_cnt_q, clr_cnt_d;
  logic                    front_q, front_d;
  logic                    seen_q, seen_d;
  logic                    err_late_q, err_late_d;
  logic                    err_under_q, err_under_d;
  logic                    rd_bank_q, oob_q;
  logic [IDX_W-1:0]        pal_addr_q, pal_addr_d;
  logic [LL:1]             vld_pipe_q;
  logic [LL:1][1:0]        sync_pipe_q;

  logic                    clr_run, wr_ok, late_evt, under_evt, oob_d;
  logic [CORDW-1:0]        lx;
  logic [1:0]              bank_we;
  logic [AW-1:0]           bank_waddr;
  logic [IDX_W-1:0]        bank_wdata;
  logic [1:0][IDX_W-1:0]   bank_rdata;
  logic                    pal_unused;

  assign clr_run   = (clr_state_q == CLR_RUN);
  assign wr_ok     = wr_en && !clr_run && !line_start && ({1'b0, wr_addr} < LINE_LIM);
  assign late_evt  = wr_en && (clr_run || line_start);
  assign under_evt = line_start && !(seen_q || wr_done);

  // The clear owns the back-bank write port; the write on a swap cycle is
  // suppressed since that bank is about to become the front.
  assign bank_waddr = clr_run ? clr_cnt_q : wr_addr[AW-1:0];
  assign bank_wdata = clr_run ? bg_idx : wr_idx;
  always_comb begin
    bank_we           = '0;
    bank_we[~front_q] = (clr_run && !line_start) || wr_ok;
  end

  assign lx    = scale2x ? (sx_next >> 1) : sx_next;
  assign oob_d = ({1'b0, lx} >= LINE_LIM);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    line_ram #(.DEPTH(LINE_PIXELS), .DW(IDX_W), .AW(AW)) u_ram (
      .clk    (clk),
      .we_i   (bank_we[b]),
      .waddr_i(bank_waddr),
      .wdata_i(bank_wdata),
      .raddr_i(lx[AW-1:0]),
      .rdata_o(bank_rdata[b])
    );
  end

  assign pal_addr_d = oob_q ? border_idx : bank_rdata[rd_bank_q];

  always_comb begin
    clr_state_d = clr_state_q;
    clr_cnt_d   = clr_cnt_q;
    front_d     = front_q;
    seen_d      = seen_q || wr_done;
    if (line_start) begin
      front_d     = !front_q;
      clr_state_d = CLR_RUN;
      clr_cnt_d   = '0;
      seen_d      = 1'b0;
    end else if (clr_run) begin
      clr_cnt_d = clr_cnt_q + AW'(1);
      if (clr_cnt_q == LAST_ADDR) clr_state_d = CLR_IDLE;
    end
    err_late_d  = (err_late_q  && !err_clr) || late_evt;
    err_under_d = (err_under_q && !err_clr) || under_evt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      clr_state_q <= CLR_IDLE;
      clr_cnt_q   <= '0;
      front_q     <= 1'b0;
      seen_q      <= 1'b0;
      err_late_q  <= 1'b0;
      err_under_q <= 1'b0;
      rd_bank_q   <= 1'b0;
      oob_q       <= 1'b0;
      pal_addr_q  <= '0;
      vld_pipe_q  <= '0;
      sync_pipe_q <= '0;
    end else begin
      clr_state_q <= clr_state_d;
      clr_cnt_q   <= clr_cnt_d;
      front_q     <= front_d;
      seen_q      <= seen_d;
      err_late_q  <= err_late_d;
      err_under_q <= err_under_d;
      // bank select follows the read, so a swap only affects later reads
      rd_bank_q   <= front_q;
      oob_q       <= oob_d;
      pal_addr_q  <= pal_addr_d;
      vld_pipe_q  <= {vld_pipe_q[LL-1:1], de_in};
      sync_pipe_q <= {sync_pipe_q[LL-1:1], {hsync_in, vsync_in}};
    end
  end

  assign pal_addr     = pal_addr_q;
  assign clear_busy   = clr_run;
  assign err_late     = err_late_q;
  assign err_underrun = err_under_q;

  // pal_data arrives one clock after pal_addr, aligned with the third sync stage
  assign vga_r     = vld_pipe_q[LL] ? pal_data[23 -: CH_W] : '0;
  assign vga_g     = vld_pipe_q[LL] ? pal_data[15 -: CH_W] : '0;
  assign vga_b     = vld_pipe_q[LL] ? pal_data[7  -: CH_W] : '0;
  assign vga_de    = vld_pipe_q[LL];
  assign vga_hsync = sync_pipe_q[LL][1];
  assign vga_vsync = sync_pipe_q[LL][0];
  assign pal_unused = ^pal_data;

endmodule
